// File: rtl/onewire_master.sv
// 1-Wire bus initiator: reset/presence, byte write and byte read time slots issued on host command.
// All bus timing is an exact multiple of CLKS_PER_US; DQ is resynchronised before any sampling.
module onewire_master #(
  parameter int CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_presence,
  output logic       dq_oe,
  input  logic       dq_i
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RST_LOW  = 3'd1;
  localparam logic [2:0] S_RST_REL  = 3'd2;
  localparam logic [2:0] S_SLOT_LOW = 3'd3;
  localparam logic [2:0] S_SLOT_REL = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Phase lengths and sample points, in microseconds.
  localparam logic [9:0] T_RST         = 10'd480;
  localparam logic [9:0] T_PRES_SAMPLE = 10'd70;
  localparam logic [9:0] T_SLOT        = 10'd70;
  localparam logic [9:0] T_W1_LOW      = 10'd6;
  localparam logic [9:0] T_W0_LOW      = 10'd60;
  localparam logic [9:0] T_RD_LOW      = 10'd1;
  localparam logic [9:0] T_RD_SAMPLE   = 10'd14;

  localparam int            PW      = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_US - 1);

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0]    us_cnt_q, us_cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    sh_q, sh_d;
  logic          pres_q, pres_d;
  logic          sync1_q, sync2_q;
  logic          dq_oe_q, dq_oe_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic          rsp_presence_q, rsp_presence_d;

  logic          accept;
  logic          us_tick;
  logic [9:0]    low_len;
  logic [9:0]    phase_len;
  logic          phase_end;
  logic          dq_s;

  assign dq_s = sync2_q;

  always_comb begin
    accept  = cmd_valid && cmd_ready_q;
    us_tick = (pre_q == PRE_MAX);

    // The low part of the slot depends on the bit being written; reads use a short pulse.
    if (op_q == OP_READ) begin
      low_len = T_RD_LOW;
    end else if (sh_q[0]) begin
      low_len = T_W1_LOW;
    end else begin
      low_len = T_W0_LOW;
    end

    case (state_q)
      S_RST_LOW:  phase_len = T_RST;
      S_RST_REL:  phase_len = T_RST;
      S_SLOT_LOW: phase_len = low_len;
      S_SLOT_REL: phase_len = T_SLOT - low_len;
      default:    phase_len = 10'd1;
    endcase

    phase_end = us_tick && (us_cnt_q == phase_len - 10'd1);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    pres_d  = pres_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d   = cmd_op;
          sh_d   = (cmd_op == OP_WRITE) ? cmd_data : 8'h00;
          bit_d  = 3'd0;
          pres_d = 1'b0;
          case (cmd_op)
            OP_RESET: state_d = S_RST_LOW;
            OP_WRITE: state_d = S_SLOT_LOW;
            OP_READ:  state_d = S_SLOT_LOW;
            default:  state_d = S_DONE;
          endcase
        end
      end

      S_RST_LOW: begin
        if (phase_end) begin
          state_d = S_RST_REL;
        end
      end

      S_RST_REL: begin
        if (us_tick && (us_cnt_q == T_PRES_SAMPLE - 10'd1)) begin
          pres_d = ~dq_s;
        end
        if (phase_end) begin
          state_d = S_DONE;
        end
      end

      S_SLOT_LOW: begin
        if (phase_end) begin
          state_d = S_SLOT_REL;
        end
      end

      S_SLOT_REL: begin
        // us_cnt restarts at release, so the read sample sits T_RD_LOW earlier in this phase.
        if ((op_q == OP_READ) && us_tick &&
            (us_cnt_q == T_RD_SAMPLE - T_RD_LOW - 10'd1)) begin
          sh_d = {dq_s, sh_q[7:1]};
        end
        if (phase_end) begin
          if (op_q == OP_WRITE) begin
            sh_d = {1'b0, sh_q[7:1]};
          end
          bit_d   = bit_q + 3'd1;
          state_d = (bit_q == 3'd7) ? S_DONE : S_SLOT_LOW;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (state_q == S_IDLE || us_tick) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + PW'(1);
    end

    if (state_d != state_q) begin
      us_cnt_d = 10'd0;
    end else if (us_tick) begin
      us_cnt_d = us_cnt_q + 10'd1;
    end else begin
      us_cnt_d = us_cnt_q;
    end
  end

  // Outputs are registered from the next state so the pad enable never glitches.
  always_comb begin
    dq_oe_d        = (state_d == S_RST_LOW) || (state_d == S_SLOT_LOW);
    cmd_ready_d    = (state_d == S_IDLE);
    rsp_valid_d    = (state_d == S_DONE);
    rsp_data_d     = rsp_data_q;
    rsp_presence_d = rsp_presence_q;
    if (state_d == S_DONE) begin
      rsp_data_d     = (op_d == OP_READ)  ? sh_d   : 8'h00;
      rsp_presence_d = (op_d == OP_RESET) ? pres_d : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pre_q          <= '0;
      us_cnt_q       <= 10'd0;
      bit_q          <= 3'd0;
      op_q           <= 2'b11;
      sh_q           <= 8'h00;
      pres_q         <= 1'b0;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      dq_oe_q        <= 1'b0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'h00;
      rsp_presence_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pre_q          <= pre_d;
      us_cnt_q       <= us_cnt_d;
      bit_q          <= bit_d;
      op_q           <= op_d;
      sh_q           <= sh_d;
      pres_q         <= pres_d;
      sync1_q        <= dq_i;
      sync2_q        <= sync1_q;
      dq_oe_q        <= dq_oe_d;
      cmd_ready_q    <= cmd_ready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_data_q     <= rsp_data_d;
      rsp_presence_q <= rsp_presence_d;
    end
  end

  assign dq_oe        = dq_oe_q;
  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_presence = rsp_presence_q;

endmodule

// File: tb/tb_onewire_master.sv
// Directed and randomized bench for onewire_master with a wired-AND DQ bus and a simple sensor responder.
module tb_onewire_master;
  localparam int C = 4;
  localparam logic [1:0] OP_RESET = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_presence;
  logic       dq_oe;
  logic       dq_i;

  logic       device_pull = 1'b0;
  assign dq_i = ~(dq_oe | device_pull);

  onewire_master #(.CLKS_PER_US(C)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_presence(rsp_presence), .dq_oe(dq_oe), .dq_i(dq_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and responder: records every master low pulse, answers presence and read slots.
  int         lowq[$];
  int         riseq[$];
  int         hi_cnt = 0;
  logic       oe_prev = 1'b0;
  int         rsp_cnt = 0;
  int         pull_wait = 0;
  int         pull_left = 0;
  logic [2:0] rd_idx = 3'd0;
  logic       presence_en = 1'b0;
  logic       read_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) rsp_cnt++;
    if (!read_en) rd_idx = 3'd0;
    if (pull_wait > 0) begin
      pull_wait--;
      if (pull_wait == 0) begin
        device_pull = 1'b1;
        pull_left   = 240 * C;
      end
    end else if (pull_left > 0) begin
      pull_left--;
      if (pull_left == 0) device_pull = 1'b0;
    end
    if (dq_oe === 1'b1 && !oe_prev) begin
      riseq.push_back(cyc);
      if (read_en) begin
        if (!rd_byte[rd_idx]) begin
          device_pull = 1'b1;
          pull_left   = 30 * C;
        end
        rd_idx = rd_idx + 3'd1;
      end
    end
    if (dq_oe === 1'b1) hi_cnt++;
    if (dq_oe !== 1'b1 && oe_prev) begin
      lowq.push_back(hi_cnt);
      if (presence_en && hi_cnt >= 400 * C) pull_wait = 15 * C;
      hi_cnt = 0;
    end
    oe_prev = (dq_oe === 1'b1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference timing from the bus rules, counted to the edge that samples rsp_valid.
  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      OP_RESET:         return 960 * C + 1;
      OP_WRITE, OP_READ: return 560 * C + 1;
      default:          return 1;
    endcase
  endfunction

  function automatic int exp_pulses(input logic [1:0] op);
    case (op)
      OP_RESET:          return 1;
      OP_WRITE, OP_READ: return 8;
      default:           return 0;
    endcase
  endfunction

  function automatic int exp_width(input logic [1:0] op, input logic [7:0] d, input int i);
    if (op == OP_RESET) return 480 * C;
    if (op == OP_READ)  return C;
    return d[i] ? 6 * C : 60 * C;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [7:0] d, output int acc);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 32'(n < 5000), 32'd1);
    acc = cyc + 1;
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int acc, output int lat);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_timeout", 32'(n < 5000), 32'd1);
    lat = cyc - acc + 1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] d, input logic [7:0] rb, input logic present);
    int acc, lat, lb, rbase, np;
    lb          = lowq.size();
    rbase       = riseq.size();
    presence_en = present;
    rd_byte     = rb;
    read_en     = (op == OP_READ);
    issue(op, d, acc);
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
    cmd_op    = 2'($urandom_range(0, 3));
    chk("busy_ready", 32'(cmd_ready), 32'd0);
    chk("start_oe", 32'(dq_oe), 32'(op != OP_NOP));
    wait_rsp(acc, lat);
    chk("latency", 32'(lat), 32'(exp_lat(op)));
    chk("rsp_data", 32'(rsp_data), (op == OP_READ) ? 32'(rb) : 32'd0);
    chk("rsp_presence", 32'(rsp_presence), (op == OP_RESET) ? 32'(present) : 32'd0);
    np = exp_pulses(op);
    chk("pulse_count", 32'(lowq.size() - lb), 32'(np));
    for (int i = 0; i < np; i++) begin
      if (lb + i < lowq.size()) chk("low_width", 32'(lowq[lb + i]), 32'(exp_width(op, d, i)));
    end
    if (np == 8 && riseq.size() - rbase == 8) begin
      for (int i = 1; i < 8; i++) chk("slot_len", 32'(riseq[rbase + i] - riseq[rbase + i - 1]), 32'(70 * C));
      chk("last_slot_len", 32'(cyc - riseq[rbase + 7]), 32'(70 * C));
    end
    @(negedge clk);
    chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    chk("ready_after", 32'(cmd_ready), 32'd1);
    read_en = 1'b0;
  endtask

  initial begin
    int a1, a2, a3, lat, r1, r2, base, rbase, n;
    logic [7:0] rb, d;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_dq_oe", 32'(dq_oe), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_presence", 32'(rsp_presence), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    run_op(OP_RESET, 8'h00, 8'h00, 1'b1);
    run_op(OP_RESET, 8'h00, 8'h00, 1'b0);
    run_op(OP_WRITE, 8'hCC, 8'h00, 1'b0);
    run_op(OP_READ,  8'h00, 8'hA5, 1'b0);
    run_op(OP_NOP,   8'h5A, 8'h00, 1'b1);

    for (int k = 0; k < 6; k++) begin
      run_op(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    // Back-to-back with cmd_valid held high throughout.
    base        = rsp_cnt;
    presence_en = 1'b1;
    read_en     = 1'b0;
    rb          = 8'($urandom);
    issue(OP_RESET, 8'h00, a1);
    cmd_op   = OP_WRITE;
    cmd_data = 8'h44;
    wait_rsp(a1, lat);
    r1 = cyc;
    chk("b2b_reset_lat", 32'(lat), 32'(exp_lat(OP_RESET)));
    chk("b2b_presence", 32'(rsp_presence), 32'd1);
    issue(OP_WRITE, 8'h44, a2);
    chk("b2b_accept_write", 32'(a2 - r1), 32'd2);
    cmd_op = OP_READ;
    wait_rsp(a2, lat);
    r2 = cyc;
    chk("b2b_write_lat", 32'(lat), 32'(exp_lat(OP_WRITE)));
    rd_byte = rb;
    read_en = 1'b1;
    issue(OP_READ, 8'h00, a3);
    cmd_valid = 1'b0;
    chk("b2b_accept_read", 32'(a3 - r2), 32'd2);
    wait_rsp(a3, lat);
    chk("b2b_read_data", 32'(rsp_data), 32'(rb));
    repeat (3) @(negedge clk);
    read_en = 1'b0;
    chk("b2b_rsp_count", 32'(rsp_cnt - base), 32'd3);

    // Reset asserted during the low phase of bit 3 of a write.
    presence_en = 1'b0;
    base        = rsp_cnt;
    rbase       = riseq.size();
    d           = 8'($urandom) & 8'hF7;
    issue(OP_WRITE, d, a1);
    cmd_valid = 1'b0;
    n = 0;
    while (riseq.size() - rbase < 4 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("midop_slot_timeout", 32'(n < 5000), 32'd1);
    chk("midop_oe_before", 32'(dq_oe), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_oe_released", 32'(dq_oe), 32'd0);
    chk("midop_ready_low", 32'(cmd_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_ready_release", 32'(cmd_ready), 32'd1);
    chk("midop_rsp_data", 32'(rsp_data), 32'd0);
    repeat (3000) @(negedge clk);
    chk("midop_no_rsp", 32'(rsp_cnt - base), 32'd0);
    chk("midop_bus_idle", 32'(dq_oe), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
